// File: rtl/uart.sv
// Memory-mapped 8N1 UART: TX FIFO + shift FSM, optional RX path.
// Define UART_RX_EN to build the receiver (sync, sampler, holding reg).
module uart #(
  parameter int TX_FIFO_DEPTH    = 8,
  parameter int BAUD_DIV_DEFAULT = 433
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_sel,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_wr,
  input  logic [11:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_st_t;

  logic        r_ready;
  logic [31:0] r_rdata;
  logic [15:0] r_div;

  logic [7:0]  r_fifo [TX_FIFO_DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;

  tx_st_t      r_tst;
  logic [15:0] r_tcnt;
  logic [2:0]  r_tbit;
  logic [7:0]  r_tsh;
  logic        r_txd;

  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic        w_sel_data;
  logic        w_sel_stat;
  logic        w_sel_div;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_tx_empty;
  logic [7:0]  w_head;
  logic [31:0] w_rdata;

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic        w_rx_ovr;

  logic        w_unused;

  assign w_unused = ^{mem_addr[1:0], mem_wdata[31:16]};

  assign w_acc      = mem_valid & mem_sel & ~r_ready;
  assign w_wr       = w_acc & mem_wr;
  assign w_rd       = w_acc & ~mem_wr;
  assign w_sel_data = (mem_addr[11:2] == 10'd0);
  assign w_sel_stat = (mem_addr[11:2] == 10'd1);
  assign w_sel_div  = (mem_addr[11:2] == 10'd2);

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  // Full is judged before any same-cycle pop
  assign w_push  = w_wr & w_sel_data & ~w_full;
  assign w_pop   = ~w_empty &
                   ((r_tst == T_IDLE) |
                    ((r_tst == T_STOP) && (r_tcnt == 16'd0)));
  assign w_head  = r_fifo[r_rp[AW-1:0]];

  assign w_tx_empty = w_empty & (r_tst == T_IDLE);

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign uart_txd  = r_txd;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp[AW-1:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_tst  <= T_IDLE;
      r_tcnt <= '0;
      r_tbit <= '0;
      r_tsh  <= '0;
      r_txd  <= 1'b1;
    end else begin
      unique case (r_tst)
        T_IDLE: begin
          if (w_pop) begin
            r_tst  <= T_START;
            r_tsh  <= w_head;
            r_tcnt <= r_div;
            r_txd  <= 1'b0;
          end
        end
        T_START: begin
          if (r_tcnt != 16'd0) begin
            r_tcnt <= r_tcnt - 16'd1;
          end else begin
            r_tst  <= T_DATA;
            r_tcnt <= r_div;
            r_tbit <= 3'd0;
            r_txd  <= r_tsh[0];
            r_tsh  <= {1'b0, r_tsh[7:1]};
          end
        end
        T_DATA: begin
          if (r_tcnt != 16'd0) begin
            r_tcnt <= r_tcnt - 16'd1;
          end else begin
            r_tcnt <= r_div;
            if (r_tbit == 3'd7) begin
              r_tst <= T_STOP;
              r_txd <= 1'b1;
            end else begin
              r_tbit <= r_tbit + 3'd1;
              r_txd  <= r_tsh[0];
              r_tsh  <= {1'b0, r_tsh[7:1]};
            end
          end
        end
        T_STOP: begin
          if (r_tcnt != 16'd0) begin
            r_tcnt <= r_tcnt - 16'd1;
          end else if (w_pop) begin
            // Chain straight into the next frame
            r_tst  <= T_START;
            r_tsh  <= w_head;
            r_tcnt <= r_div;
            r_txd  <= 1'b0;
          end else begin
            r_tst <= T_IDLE;
          end
        end
        default: r_tst <= T_IDLE;
      endcase
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_st_t;

  logic [2:0]  r_sync;
  rx_st_t      r_rst;
  logic [15:0] r_rcnt;
  logic [2:0]  r_rbit;
  logic [7:0]  r_rsh;
  logic [7:0]  r_rbyte;
  logic        r_rvalid;
  logic        r_rovr;

  logic        w_rx_in;
  logic        w_fall;
  logic [16:0] w_div1;
  logic [15:0] w_half;
  logic        w_rx_done;
  logic        w_rd_data;
  logic        w_clr_ovr;

  assign w_rx_in   = r_sync[1];
  assign w_fall    = r_sync[2] & ~r_sync[1];
  assign w_div1    = {1'b0, r_div} + 17'd1;
  assign w_half    = w_div1[16:1];
  assign w_rx_done = (r_rst == R_STOP) && (r_rcnt == 16'd0) && w_rx_in;
  assign w_rd_data = w_rd & w_sel_data;
  assign w_clr_ovr = w_wr & w_sel_stat & mem_wdata[3];

  assign w_rx_byte  = r_rbyte;
  assign w_rx_valid = r_rvalid;
  assign w_rx_ovr   = r_rovr;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_sync <= 3'b111;
    else         r_sync <= {r_sync[1:0], uart_rxd};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rst  <= R_IDLE;
      r_rcnt <= '0;
      r_rbit <= '0;
      r_rsh  <= '0;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          if (w_fall) begin
            r_rst  <= R_START;
            r_rcnt <= w_half;
          end
        end
        R_START: begin
          if (r_rcnt > 16'd1) begin
            r_rcnt <= r_rcnt - 16'd1;
          end else if (w_rx_in) begin
            r_rst <= R_IDLE;
          end else begin
            r_rst  <= R_DATA;
            r_rcnt <= r_div;
            r_rbit <= 3'd0;
          end
        end
        R_DATA: begin
          if (r_rcnt != 16'd0) begin
            r_rcnt <= r_rcnt - 16'd1;
          end else begin
            r_rsh  <= {w_rx_in, r_rsh[7:1]};
            r_rcnt <= r_div;
            if (r_rbit == 3'd7) r_rst <= R_STOP;
            else                r_rbit <= r_rbit + 3'd1;
          end
        end
        R_STOP: begin
          if (r_rcnt != 16'd0) r_rcnt <= r_rcnt - 16'd1;
          else                 r_rst  <= R_IDLE;
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rbyte  <= '0;
      r_rvalid <= 1'b0;
      r_rovr   <= 1'b0;
    end else begin
      if (w_clr_ovr) r_rovr <= 1'b0;
      // A byte landing on a DATA read wins and is not an overrun
      if (w_rx_done) begin
        r_rbyte  <= r_rsh;
        r_rvalid <= 1'b1;
        if (r_rvalid & ~w_rd_data) r_rovr <= 1'b1;
      end else if (w_rd_data) begin
        r_rvalid <= 1'b0;
      end
    end
  end
`else
  logic w_unused_rx;

  assign w_unused_rx = uart_rxd;
  assign w_rx_byte   = '0;
  assign w_rx_valid  = 1'b0;
  assign w_rx_ovr    = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_data: w_rdata = {24'd0, w_rx_byte};
      w_sel_stat: w_rdata = {28'd0, w_rx_ovr, w_rx_valid,
                             w_tx_empty, w_full};
      w_sel_div:  w_rdata = {16'd0, r_div};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_div   <= 16'(BAUD_DIV_DEFAULT);
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_rd ? w_rdata : 32'd0;
      if (w_wr & w_sel_div) r_div <= mem_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_uart.sv
// Randomized scoreboard bench for uart: bus reads and TX frames are
// checked by monitors against expectations queued by the stimulus.
module tb_uart;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        mem_sel = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_wr = 1'b0;
  logic [11:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_div = 433;

  typedef struct {
    logic [31:0] v;
    string       nm;
  } rd_t;

  rd_t        rd_q[$];
  logic [7:0] tx_q[$];
  int         st_q[$];

  localparam logic [11:0] A_DATA = 12'h000;
  localparam logic [11:0] A_STAT = 12'h004;
  localparam logic [11:0] A_DIV  = 12'h008;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart dut (
    .clk       (clk),
    .reset_    (reset_),
    .mem_sel   (mem_sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .uart_txd  (uart_txd),
    .uart_rxd  (uart_rxd)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [11:0] a,
                     input logic [31:0] d, input logic [31:0] e,
                     input string nm);
    int k;
    @(negedge clk);
    mem_sel = 1'b1;
    mem_valid = 1'b1;
    mem_wr = wr;
    mem_addr = a;
    mem_wdata = d;
    if (!wr) rd_q.push_back('{e, nm});
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!mem_ready && k < 20);
    chk({nm, "_lat"}, k, 1);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_sel = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'd0, "wr");
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e,
                    input string nm);
    bus(1'b0, a, 32'd0, e, nm);
  endtask

  task automatic send(input logic [7:0] b);
    tx_q.push_back(b);
    wr(A_DATA, {24'd0, b});
  endtask

  task automatic rx_send(input logic [7:0] b, input logic sb);
    logic [9:0] fr;
    fr = {sb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = fr[i];
      repeat (m_div) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * (m_div + 1)) @(negedge clk);
  endtask

  // Bus read monitor
  initial begin : rdmon
    rd_t r;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ready && !mem_wr) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexp: got %0h expected none", mem_rdata);
        end else begin
          r = rd_q.pop_front();
          chk(r.nm, mem_rdata, r.v);
        end
      end else if (!mem_ready) begin
        chk("rdata_idle", mem_rdata, 32'd0);
      end
    end
  end

  // Serial TX monitor: every cycle of a frame must carry its bit
  initial begin : txmon
    logic       prev;
    logic       had;
    logic       abort;
    logic [7:0] eb;
    logic [9:0] fr;
    int         errs;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_) begin
        prev = 1'b1;
      end else if (prev && !uart_txd) begin
        st_q.push_back(cyc);
        had = (tx_q.size() != 0);
        eb = 8'h00;
        if (had) begin
          eb = tx_q.pop_front();
        end else begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexp: got frame expected none");
        end
        fr = {1'b1, eb, 1'b0};
        errs = 0;
        abort = 1'b0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c <= m_div && !abort; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge clk);
              #2;
            end
            if (!reset_) abort = 1'b1;
            else if (uart_txd !== fr[b]) errs++;
          end
        end
        if (had && !abort)
          chk($sformatf("tx_frame_%02h_errs", eb), errs, 0);
        prev = abort ? 1'b1 : uart_txd;
      end else begin
        prev = uart_txd;
      end
    end
  end

  initial begin : main
    int n;
    int d;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    chk("rst_txd_held", uart_txd, 1);
    chk("rst_ready", mem_ready, 0);
    reset_ = 1'b1;
    @(negedge clk);
    chk("rel_txd", uart_txd, 1);
    rd(A_STAT, 32'h2, "rst_status");
    rd(A_DIV, 32'd433, "rst_div");
    rd(12'h00C, 32'd0, "rd_00c");
    rd(A_DATA, 32'd0, "rst_data");
    wr(12'h00C, 32'hFFFF_FFFF);
    rd(12'h00C, 32'd0, "rd_00c_after_wr");
    rd(A_DIV, 32'd433, "div_after_bad_wr");

    m_div = 3;
    wr(A_DIV, 32'd3);
    rd(A_DIV, 32'd3, "div3");

    // Single frame
    send(8'h55);
    rd(A_STAT, 32'h0, "busy_status");
    repeat (50) @(negedge clk);
    rd(A_STAT, 32'h2, "idle_after_55");

    // Overfill: 0x09 must be dropped, frames chained with no gap
    st_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_q.push_back(i[7:0]);
      wr(A_DATA, i);
    end
    rd(A_STAT, 32'h1, "full_status");
    repeat (9 * 40 + 20) @(negedge clk);
    rd(A_STAT, 32'h2, "idle_after_burst");
    chk("burst_frames", st_q.size(), 9);
    for (int i = 1; i < st_q.size(); i++)
      chk($sformatf("gap_%0d", i), st_q[i] - st_q[i-1], 40);

    // Random divisors and bursts
    for (int t = 0; t < 4; t++) begin
      d = $urandom_range(6, 1);
      n = $urandom_range(7, 1);
      m_div = d;
      wr(A_DIV, d);
      rd(A_DIV, d, "rand_div");
      for (int i = 0; i < n; i++) send(8'($urandom));
      repeat (n * 10 * (d + 1) + 30) @(negedge clk);
      rd(A_STAT, 32'h2, "rand_idle");
    end

    m_div = 3;
    wr(A_DIV, 32'd3);

`ifdef UART_RX_EN
    rx_send(8'hA3, 1'b1);
    rd(A_STAT, 32'h6, "rx_a3_status");
    rd(A_DATA, 32'hA3, "rx_a3_data");
    rd(A_STAT, 32'h2, "rx_a3_cleared");

    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    rd(A_STAT, 32'hE, "ovr_status");
    rd(A_DATA, 32'h22, "ovr_data");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h2, "ovr_cleared");

    @(negedge clk);
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd(A_STAT, 32'h2, "glitch_status");

    rx_send(8'h33, 1'b1);
    rd(A_STAT, 32'h6, "pre_frm_status");
    rx_send(8'h5A, 1'b0);
    rd(A_STAT, 32'h6, "frm_status");
    rd(A_DATA, 32'h33, "frm_data");
    rd(A_STAT, 32'h2, "frm_cleared");

    for (int t = 0; t < 3; t++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1);
      rd(A_STAT, 32'h6, "rand_rx_status");
      rd(A_DATA, {24'd0, b}, "rand_rx_data");
      rd(A_STAT, 32'h2, "rand_rx_cleared");
    end
`else
    rx_send(8'hA3, 1'b1);
    rd(A_STAT, 32'h2, "norx_status");
    rd(A_DATA, 32'd0, "norx_data");
`endif

    // Reset in the middle of a frame of zeros
    send(8'h00);
    send(8'h4D);
    send(8'h5E);
    repeat (15) @(posedge clk);
    #3;
    chk("pre_rst_txd", uart_txd, 0);
    reset_ = 1'b0;
    #1;
    chk("async_rst_txd", uart_txd, 1);
    tx_q.delete();
    m_div = 433;
    @(negedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    rd(A_STAT, 32'h2, "post_rst_status");
    rd(A_DIV, 32'd433, "post_rst_div");
    repeat (100) @(negedge clk);
    chk("post_rst_txd", uart_txd, 1);

    chk("tx_pending", tx_q.size(), 0);
    chk("rd_pending", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
